dff_pipe: RTL and testbench



---
 rtl/dff_pipe.sv | 127 ++++++++++++
 tb/tb_dff_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipe.sv
// ---------------------------------------------------------------------------
// dff_pipe -- parametrised D-flip-flop delay line with per-stage valid bits.
//
// A WIDTH-bit sample and its valid bit travel through DEPTH register stages.
// The whole line advances only when en_i is high. clr_i flushes every stage
// synchronously and takes priority over en_i. With CLEAN=1 a stage whose
// incoming valid is low loads RST_VAL instead of the incoming data, so
// invalid slots never carry stale or unknown data. occ_o tracks how many
// stages currently hold valid data.
//
// Ports
//   clk_i     in   1        clock, rising edge
//   rst_ni    in   1        asynchronous active-low reset
//   en_i      in   1        advance enable (0 = every stage holds)
//   clr_i     in   1        synchronous flush of all stages
//   d_i       in   WIDTH    input data
//   d_vld_i   in   1        input data valid
//   q_o       out  WIDTH    data at the last stage (registered)
//   q_vld_o   out  1        valid at the last stage (registered)
//   occ_o     out  OCC_W    number of stages holding valid data, 0..DEPTH
// ---------------------------------------------------------------------------
module dff_pipe #(
    parameter int              WIDTH   = 8,
    parameter int              DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter bit              CLEAN   = 1'b1,
    localparam int             OCC_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             d_vld_i,
    output logic [WIDTH-1:0] q_o,
    output logic             q_vld_o,
    output logic [OCC_W-1:0] occ_o
);

    if (DEPTH < 1) begin : g_depth_check
        $error("dff_pipe: DEPTH must be >= 1");
    end

    logic [WIDTH-1:0] data_q    [DEPTH];
    logic [WIDTH-1:0] data_d    [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // What each stage would receive on an advancing edge.
    logic [WIDTH-1:0] in_data_s [DEPTH];
    logic [DEPTH-1:0] in_vld_s;

    // Build the per-stage incoming data/valid: stage 0 sees the input port,
    // every later stage sees its predecessor.
    always_comb begin
        in_data_s[0] = d_i;
        in_vld_s[0]  = d_vld_i;
        for (int i = 1; i < DEPTH; i++) begin
            in_data_s[i] = data_q[i-1];
            in_vld_s[i]  = vld_q[i-1];
        end
    end

    // Next-state logic: flush beats advance, advance beats hold.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
        end
        vld_d = vld_q;
        occ_d = occ_q;

        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = RST_VAL;
            end
            vld_d = '0;
            occ_d = '0;
        end else if (en_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                // Cleaning keeps invalid slots at a known value, which also
                // stops an unknown d_i from leaking down the line.
                if (CLEAN && !in_vld_s[i]) begin
                    data_d[i] = RST_VAL;
                end else begin
                    data_d[i] = in_data_s[i];
                end
            end
            vld_d = in_vld_s;
            // Incremental count: one sample may enter and one may leave per
            // advancing edge, so occupancy moves by at most one.
            if (d_vld_i && !vld_q[DEPTH-1]) begin
                occ_d = occ_q + OCC_W'(1'b1);
            end else if (!d_vld_i && vld_q[DEPTH-1]) begin
                occ_d = occ_q - OCC_W'(1'b1);
            end else begin
                occ_d = occ_q;
            end
        end else begin
            vld_d = vld_q;
            occ_d = occ_q;
        end
    end

    // State registers with asynchronous reset to the programmed value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RST_VAL;
            end
            vld_q <= '0;
            occ_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            vld_q <= vld_d;
            occ_q <= occ_d;
        end
    end

    assign q_o     = data_q[DEPTH-1];
    assign q_vld_o = vld_q[DEPTH-1];
    assign occ_o   = occ_q;

endmodule

// File: tb/tb_dff_pipe.sv
// ---------------------------------------------------------------------------
// Testbench for dff_pipe. Three instances share one stimulus stream:
//   u_main : WIDTH=8, DEPTH=4, RST_VAL=A5, CLEAN=1
//   u_c0   : WIDTH=8, DEPTH=4, RST_VAL=A5, CLEAN=0
//   u_d1   : WIDTH=8, DEPTH=1, RST_VAL=A5, CLEAN=1
// Each instance is mirrored by a queue model: an advancing edge pushes the
// (possibly cleaned) sample at the front and drops the oldest at the back.
// ---------------------------------------------------------------------------
module tb_dff_pipe;

    typedef logic [8:0] ent_t;          // {valid, data}
    typedef ent_t       ent_q_t [$];

    localparam logic [7:0] RV = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [7:0] d;
    logic       d_vld;

    logic [7:0] q4, qc, q1;
    logic       v4, vc, v1;
    logic [2:0] o4, oc;
    logic [0:0] o1;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    ent_q_t m4, mc, m1;

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(RV), .CLEAN(1'b1)) u_main (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .d_i(d),
        .d_vld_i(d_vld), .q_o(q4), .q_vld_o(v4), .occ_o(o4));

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(RV), .CLEAN(1'b0)) u_c0 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .d_i(d),
        .d_vld_i(d_vld), .q_o(qc), .q_vld_o(vc), .occ_o(oc));

    dff_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(RV), .CLEAN(1'b1)) u_d1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .d_i(d),
        .d_vld_i(d_vld), .q_o(q1), .q_vld_o(v1), .occ_o(o1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ent_q_t fill(int n);
        ent_q_t r;
        r = {};
        for (int i = 0; i < n; i++) r.push_back({1'b0, RV});
        return r;
    endfunction

    function automatic int count_vld(ent_q_t m);
        int c = 0;
        foreach (m[i]) if (m[i][8]) c++;
        return c;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: reset/flush empties every slot, an advance is a
    // push-front/pop-back; cleaning at entry is enough because a sample's
    // valid bit travels with it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4 = fill(4); mc = fill(4); m1 = fill(1);
        end else if (clr) begin
            m4 = fill(4); mc = fill(4); m1 = fill(1);
        end else if (en) begin
            m4.push_front({d_vld, d_vld ? d : RV}); void'(m4.pop_back());
            mc.push_front({d_vld, d});              void'(mc.pop_back());
            m1.push_front({d_vld, d_vld ? d : RV}); void'(m1.pop_back());
        end
    end

    // Compare every DUT output against the model once per cycle.
    always @(negedge clk) begin
        if (started) begin
            check("main_q",   {24'h0, q4}, {24'h0, m4[3][7:0]});
            check("main_vld", {31'h0, v4}, {31'h0, m4[3][8]});
            check("main_occ", {29'h0, o4}, 32'(count_vld(m4)));
            check("c0_q",     {24'h0, qc}, {24'h0, mc[3][7:0]});
            check("c0_vld",   {31'h0, vc}, {31'h0, mc[3][8]});
            check("c0_occ",   {29'h0, oc}, 32'(count_vld(mc)));
            check("d1_q",     {24'h0, q1}, {24'h0, m1[0][7:0]});
            check("d1_vld",   {31'h0, v1}, {31'h0, m1[0][8]});
            check("d1_occ",   {31'h0, o1}, 32'(count_vld(m1)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic push(input logic [7:0] val);
        en = 1'b1; d_vld = 1'b1; d = val;
        tick();
    endtask

    initial begin
        logic [2:0] occ_seq [7];
        occ_seq = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        rst_n = 1'b1; en = 1'b0; clr = 1'b0; d = 8'h00; d_vld = 1'b0;

        // 1. asynchronous reset with no clock edge
        #2 rst_n = 1'b0;
        #1;
        check("t1_q",   {24'h0, q4}, {24'h0, RV});
        check("t1_vld", {31'h0, v4}, 32'h0);
        check("t1_occ", {29'h0, o4}, 32'h0);
        #9 rst_n = 1'b1;
        started = 1'b1;
        tick();

        // 2. three samples then bubbles
        for (int k = 0; k < 7; k++) begin
            en = 1'b1;
            d_vld = (k < 3) ? 1'b1 : 1'b0;
            d = (k < 3) ? 8'(k + 1) : 8'h00;
            tick();
            check("t2_occ", {29'h0, o4}, {29'h0, occ_seq[k]});
            if (k >= 3 && k <= 5) begin
                check("t2_q",   {24'h0, q4}, 32'(k - 2));
                check("t2_vld", {31'h0, v4}, 32'h1);
            end else begin
                check("t2_vld", {31'h0, v4}, 32'h0);
            end
        end

        // 3. stall with two samples in flight
        push(8'h11); push(8'h22);
        en = 1'b0; d_vld = 1'b1; d = 8'hEE;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_stall_occ", {29'h0, o4}, 32'h2);
            check("t3_stall_vld", {31'h0, v4}, 32'h0);
        end
        en = 1'b1; d_vld = 1'b0;
        tick(); tick();
        check("t3_q0", {24'h0, q4}, 32'h11);
        tick();
        check("t3_q1", {24'h0, q4}, 32'h22);
        tick();
        check("t3_occ_end", {29'h0, o4}, 32'h0);

        // 4. flush a full pipeline while a sample is offered
        push(8'h41); push(8'h42); push(8'h43); push(8'h44);
        check("t4_full", {29'h0, o4}, 32'h4);
        clr = 1'b1; en = 1'b1; d_vld = 1'b1; d = 8'hFF;
        tick();
        clr = 1'b0;
        check("t4_occ", {29'h0, o4}, 32'h0);
        check("t4_vld", {31'h0, v4}, 32'h0);
        check("t4_q",   {24'h0, q4}, {24'h0, RV});
        d_vld = 1'b0; d = 8'h00;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t4_no_ff", {31'h0, (v4 || q4 == 8'hFF)}, 32'h0);
        end

        // 5. reset pulse mid-stream, then a fresh sample
        push(8'h51); push(8'h52); push(8'h53);
        check("t5_occ3", {29'h0, o4}, 32'h3);
        rst_n = 1'b0;
        #1;
        check("t5_rst_occ", {29'h0, o4}, 32'h0);
        check("t5_rst_q",   {24'h0, q4}, {24'h0, RV});
        rst_n = 1'b1;
        push(8'h33);
        check("t5_occ1", {29'h0, o4}, 32'h1);
        d_vld = 1'b0;
        tick(); check("t5_vld_a", {31'h0, v4}, 32'h0);
        tick(); check("t5_vld_b", {31'h0, v4}, 32'h0);
        tick();
        check("t5_q",   {24'h0, q4}, 32'h33);
        check("t5_vld", {31'h0, v4}, 32'h1);
        tick();

        // 6. cleaning on/off, and the single-stage variant
        en = 1'b1; d_vld = 1'b0; d = 8'h5A;
        tick();
        check("t6_d1_clean", {24'h0, q1}, {24'h0, RV});
        tick(); tick(); tick();
        check("t6_clean_q",   {24'h0, q4}, {24'h0, RV});
        check("t6_noclean_q", {24'h0, qc}, 32'h5A);
        check("t6_noclean_v", {31'h0, vc}, 32'h0);
        d = 8'h3C; d_vld = 1'b1;
        tick();
        check("t6_d1_q", {24'h0, q1}, 32'h3C);
        check("t6_d1_v", {31'h0, v1}, 32'h1);
        en = 1'b0; d = 8'h77;
        tick();
        check("t6_d1_hold", {24'h0, q1}, 32'h3C);
        en = 1'b1; d_vld = 1'b0;
        tick();
        check("t6_d1_bubble", {24'h0, q1}, {24'h0, RV});

        // Randomised traffic with occasional flushes and reset pulses.
        for (int k = 0; k < 600; k++) begin
            en    = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 19) == 0);
            d_vld = $urandom_range(0, 1) == 1;
            d     = 8'($urandom);
            tick();
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        clr = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
